id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage RISC-V (RV32I) pipeline.
- Sits directly downstream of the register file:
  - drives its rs1/rs2 read indices;
  - consumes rs1_data/rs2_data;
  - applies the WB→ID write-through bypass;
  - generates immediates and control;
  - detects load-use hazards;
  - registers everything into the EX stage, with flush and hold support.

Parameters:
XLEN, 32, datapath width (only 32 supported).
NOP_ON_ILLEGAL, 1, 1 = unknown opcode enters EX as a bubble and pulses id_ex_illegal.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction from IF/ID
if_id_pc  in  32  PC of that instruction
rs1_indice  out  5  instr[19:15], combinational, to register file
rs2_indice  out  5  instr[24:20], combinational, to register file
rs1_data  in  32  register file read port 1
rs2_data  in  32  register file read port 2
wb_regwrite  in  1  WB stage write enable
wb_rd  in  5  WB destination
wb_write_data  in  32  WB data
ex_flush  in  1  taken branch/jump resolved in EX; kill ID
mem_hold  in  1  downstream stall; ID/EX must hold
stall_if  out  1  combinational; hold PC and IF/ID this cycle
id_ex_valid, id_ex_pc[32], id_ex_rs1_val[32], id_ex_rs2_val[32], id_ex_imm[32]  out  registered EX payload
id_ex_rd[5], id_ex_rs1[5], id_ex_rs2[5], id_ex_funct3[3], id_ex_funct7b5[1]  out  registered fields
id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_alusrc, id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_lui, id_ex_auipc  out  1 each, registered control
id_ex_aluop  out  2  00 add, 01 branch compare, 10 R/I funct decode
id_ex_illegal  out  1  registered, one-cycle pulse per illegal instruction

Behaviour:
- Reset (reset=0 at clk edge): all id_ex_* outputs become 0. This is the bubble encoding: every field is zero.
- Opcode decode:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - Anything else is illegal.
- Immediates are sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm = 0
- regwrite:
  - Set for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
  - Forced to 0 when rd==0.
- Source usage:
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
- Bypass: if wb_regwrite && wb_rd!=0 && wb_rd==rs1_indice, then the latched rs1 value is wb_write_data; otherwise it is rs1_data. Same rule for rs2. This is needed because the register file writes at the clock edge.
- Load-use hazard (combinational, lu):
  - Condition: if_id_valid, id_ex_valid, id_ex_memread, id_ex_rd!=0, and id_ex_rd matches a *used* source.
  - stall_if = (lu | mem_hold) & ~ex_flush.
- Next-state priority at each edge:
  1. reset → bubble.
  2. ex_flush → bubble, regardless of mem_hold or lu.
  3. mem_hold → all id_ex_* retain their value, except id_ex_illegal, which goes to 0.
  4. lu → bubble. The same instruction re-decodes next cycle, so the stall lasts exactly one cycle.
  5. !if_id_valid → bubble.
  6. Otherwise, load the decoded instruction with id_ex_valid=1.
- Illegal opcode (NOP_ON_ILLEGAL=1): loads a bubble but with id_ex_illegal=1 and id_ex_pc set. The pulse is suppressed by flush.
- Latency: the instruction presented at cycle N appears on id_ex_* after edge N+1, unless stalled.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) at pc 0x0 → next cycle: valid=1, rd=1, imm=5, regwrite=1, alusrc=1, aluop=10, funct3=0.
- Store 0xFE30AE23 (sw x3,-4(x1)), with rs1_data=0x100 and rs2_data=0xAB → imm=0xFFFFFFFC, memwrite=1, regwrite=0, rs1_val=0x100, rs2_val=0xAB.
- Load-use: 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 (add x3,x2,x1):
  - add present with lw in ID/EX → stall_if=1 for one cycle; ID/EX becomes a bubble.
  - Next cycle the add is loaded with stall_if=0.
- Bypass: same-cycle wb_regwrite=1, wb_rd=2, wb_write_data=0xDEADBEEF, while decoding the add with rs1_data=0 → id_ex_rs1_val=0xDEADBEEF. With wb_rd=0 → rs1_val=rs1_data.
- Flush vs stall: ex_flush=1 together with mem_hold=1 and lu=1 → next cycle ID/EX is all zeros and stall_if=0. mem_hold alone for 3 cycles → id_ex_* frozen and stall_if=1 throughout.
- Illegal 0xFFFFFFFF at pc 0x40 → id_ex_illegal=1 for one cycle, id_ex_valid=0, id_ex_pc=0x40. Reset asserted mid-stall → all outputs 0 next edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle between IF/ID, the register file, WB and the EX stage as seen by id_ex_stage.
// slave = the decode stage itself, master = whoever drives IF/ID, the regfile ports and WB.
interface id_ex_stage_if;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [4:0]  rs1_indice;
  logic [4:0]  rs2_indice;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        ex_flush;
  logic        mem_hold;
  logic        stall_if;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_rs1_val;
  logic [31:0] id_ex_rs2_val;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_regwrite;
  logic        id_ex_memread;
  logic        id_ex_memwrite;
  logic        id_ex_alusrc;
  logic        id_ex_branch;
  logic        id_ex_jal;
  logic        id_ex_jalr;
  logic        id_ex_lui;
  logic        id_ex_auipc;
  logic [1:0]  id_ex_aluop;
  logic        id_ex_illegal;

  modport slave (
    input  if_id_valid, if_id_instr, if_id_pc, rs1_data, rs2_data,
           wb_regwrite, wb_rd, wb_write_data, ex_flush, mem_hold,
    output rs1_indice, rs2_indice, stall_if,
           id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
           id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_funct3, id_ex_funct7b5,
           id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_alusrc,
           id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_lui, id_ex_auipc,
           id_ex_aluop, id_ex_illegal
  );

  modport master (
    output if_id_valid, if_id_instr, if_id_pc, rs1_data, rs2_data,
           wb_regwrite, wb_rd, wb_write_data, ex_flush, mem_hold,
    input  rs1_indice, rs2_indice, stall_if,
           id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
           id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_funct3, id_ex_funct7b5,
           id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_alusrc,
           id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_lui, id_ex_auipc,
           id_ex_aluop, id_ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: immediates, control, WB bypass,
// load-use detection, flush and hold. A bubble is the all-zero ID/EX payload.
module id_ex_stage #(
  parameter int XLEN           = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            alusrc;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic [1:0]      aluop;
    logic            illegal;
  } payload_t;

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_use_rs1, w_use_rs2, w_illegal, w_load_use;
  payload_t        w_dec;
  payload_t        w_next;
  payload_t        r_q;

  assign w_instr  = bus.if_id_instr;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  always_comb begin
    w_dec          = '0;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_illegal      = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.pc       = bus.if_id_pc;
    w_dec.rd       = w_rd;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.funct3   = w_instr[14:12];
    w_dec.funct7b5 = w_instr[30];
    // The regfile writes on the same edge we latch, so WB data must be forwarded here.
    w_dec.rs1_val  = (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs1)
                     ? bus.wb_write_data : bus.rs1_data;
    w_dec.rs2_val  = (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs2)
                     ? bus.wb_write_data : bus.rs2_data;
    case (w_opcode)
      OP_R:      begin w_dec.regwrite = 1'b1; w_dec.aluop = 2'b10; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_I:      begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 2'b10;
                       w_dec.imm = w_imm_i; w_use_rs1 = 1'b1; end
      OP_LOAD:   begin w_dec.regwrite = 1'b1; w_dec.memread = 1'b1; w_dec.alusrc = 1'b1;
                       w_dec.imm = w_imm_i; w_use_rs1 = 1'b1; end
      OP_STORE:  begin w_dec.memwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.imm = w_imm_s;
                       w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_BRANCH: begin w_dec.branch = 1'b1; w_dec.aluop = 2'b01; w_dec.imm = w_imm_b;
                       w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_JAL:    begin w_dec.regwrite = 1'b1; w_dec.jal = 1'b1; w_dec.imm = w_imm_j; end
      OP_JALR:   begin w_dec.regwrite = 1'b1; w_dec.jalr = 1'b1; w_dec.alusrc = 1'b1;
                       w_dec.imm = w_imm_i; w_use_rs1 = 1'b1; end
      OP_LUI:    begin w_dec.regwrite = 1'b1; w_dec.lui = 1'b1; w_dec.alusrc = 1'b1; w_dec.imm = w_imm_u; end
      OP_AUIPC:  begin w_dec.regwrite = 1'b1; w_dec.auipc = 1'b1; w_dec.alusrc = 1'b1; w_dec.imm = w_imm_u; end
      default:   w_illegal = 1'b1;
    endcase
    if (w_rd == 5'd0) w_dec.regwrite = 1'b0;
  end

  assign w_load_use = bus.if_id_valid && r_q.valid && r_q.memread && (r_q.rd != 5'd0) &&
                      ((w_use_rs1 && r_q.rd == w_rs1) || (w_use_rs2 && r_q.rd == w_rs2));

  // Upstream handshake: if_id_valid qualifies the IF/ID word; stall_if is the inverse of
  // ready -- while high, IF must present the same instruction again next cycle.
  assign bus.stall_if = (w_load_use || bus.mem_hold) && !bus.ex_flush;

  always_comb begin
    w_next = '0;
    if (bus.ex_flush) begin
      w_next = '0;
    end else if (bus.mem_hold) begin
      w_next         = r_q;
      w_next.illegal = 1'b0;
    end else if (w_load_use || !bus.if_id_valid) begin
      w_next = '0;
    end else if (w_illegal) begin
      w_next.pc      = bus.if_id_pc;
      w_next.illegal = NOP_ON_ILLEGAL;
    end else begin
      w_next = w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_q <= '0;
    else        r_q <= w_next;
  end

  assign bus.rs1_indice     = w_rs1;
  assign bus.rs2_indice     = w_rs2;
  assign bus.id_ex_valid    = r_q.valid;
  assign bus.id_ex_pc       = r_q.pc;
  assign bus.id_ex_rs1_val  = r_q.rs1_val;
  assign bus.id_ex_rs2_val  = r_q.rs2_val;
  assign bus.id_ex_imm      = r_q.imm;
  assign bus.id_ex_rd       = r_q.rd;
  assign bus.id_ex_rs1      = r_q.rs1;
  assign bus.id_ex_rs2      = r_q.rs2;
  assign bus.id_ex_funct3   = r_q.funct3;
  assign bus.id_ex_funct7b5 = r_q.funct7b5;
  assign bus.id_ex_regwrite = r_q.regwrite;
  assign bus.id_ex_memread  = r_q.memread;
  assign bus.id_ex_memwrite = r_q.memwrite;
  assign bus.id_ex_alusrc   = r_q.alusrc;
  assign bus.id_ex_branch   = r_q.branch;
  assign bus.id_ex_jal      = r_q.jal;
  assign bus.id_ex_jalr     = r_q.jalr;
  assign bus.id_ex_lui      = r_q.lui;
  assign bus.id_ex_auipc    = r_q.auipc;
  assign bus.id_ex_aluop    = r_q.aluop;
  assign bus.id_ex_illegal  = r_q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction decode vectors plus
// hand-written sequences for load-use, hold, flush, illegal and reset-under-stall.
module tb_id_ex_stage;
  localparam logic [8:0] C_RW   = 9'b1_0000_0000;
  localparam logic [8:0] C_MR   = 9'b0_1000_0000;
  localparam logic [8:0] C_MW   = 9'b0_0100_0000;
  localparam logic [8:0] C_AS   = 9'b0_0010_0000;
  localparam logic [8:0] C_BR   = 9'b0_0001_0000;
  localparam logic [8:0] C_JAL  = 9'b0_0000_1000;
  localparam logic [8:0] C_JALR = 9'b0_0000_0100;
  localparam logic [8:0] C_LUI  = 9'b0_0000_0010;
  localparam logic [8:0] C_AUI  = 9'b0_0000_0001;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [8:0]  ctrl;
    logic [1:0]  aluop;
    logic        illegal;
  } out_t;

  typedef struct {
    string       name;
    logic        if_valid;
    logic [31:0] instr, pc, r1, r2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    out_t        exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [159:0] exp_q[$];
  vec_t vecs[$];

  id_ex_stage_if bus();

  id_ex_stage #(.XLEN(32), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic v, input logic [31:0] pc, r1, r2, imm,
                              input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                              input logic f7, input logic [8:0] ctrl, input logic [1:0] aluop,
                              input logic ill);
    out_t o;
    o = '{v, pc, r1, r2, imm, rd, rs1, rs2, f3, f7, ctrl, aluop, ill};
    return o;
  endfunction

  function automatic out_t act_out();
    out_t o;
    o = {bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_rs1_val, bus.id_ex_rs2_val, bus.id_ex_imm,
         bus.id_ex_rd, bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_funct3, bus.id_ex_funct7b5,
         bus.id_ex_regwrite, bus.id_ex_memread, bus.id_ex_memwrite, bus.id_ex_alusrc,
         bus.id_ex_branch, bus.id_ex_jal, bus.id_ex_jalr, bus.id_ex_lui, bus.id_ex_auipc,
         bus.id_ex_aluop, bus.id_ex_illegal};
    return o;
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] instr, pc, r1, r2,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic fl, input logic hold);
    bus.if_id_valid   = v;
    bus.if_id_instr   = instr;
    bus.if_id_pc      = pc;
    bus.rs1_data      = r1;
    bus.rs2_data      = r2;
    bus.wb_regwrite   = we;
    bus.wb_rd         = wrd;
    bus.wb_write_data = wd;
    bus.ex_flush      = fl;
    bus.mem_hold      = hold;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic simple(input logic [31:0] instr, pc, r1, r2, input logic fl, hold);
    drive(1'b1, instr, pc, r1, r2, 1'b0, 5'd0, 32'h0, fl, hold);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = act_out();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_idx(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    out_t e_addi;
    out_t got_sb;
    n_checks = 0;
    n_pass   = 0;

    vecs.push_back('{"addi_x1_5",    1'b1, 32'h00500093, 32'h00, 32'h0,    32'h22, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h00, 32'h0, 32'h22, 32'h5, 5'd1, 5'd0, 5'd5, 3'd0, 0, C_RW|C_AS, 2'b10, 0)});
    vecs.push_back('{"sw_x3_m4_x1",  1'b1, 32'hFE30AE23, 32'h04, 32'h100,  32'hAB, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h04, 32'h100, 32'hAB, 32'hFFFFFFFC, 5'd28, 5'd1, 5'd3, 3'd2, 1, C_MW|C_AS, 2'b00, 0)});
    vecs.push_back('{"add_byp_rs1",  1'b1, 32'h001101B3, 32'h08, 32'h0,    32'h7, 1'b1, 5'd2, 32'hDEADBEEF,
      mk(1, 32'h08, 32'hDEADBEEF, 32'h7, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0)});
    vecs.push_back('{"add_byp_x0",   1'b1, 32'h001101B3, 32'h08, 32'h55,   32'h7, 1'b1, 5'd0, 32'hDEADBEEF,
      mk(1, 32'h08, 32'h55, 32'h7, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0)});
    vecs.push_back('{"add_byp_rs2",  1'b1, 32'h001101B3, 32'h0C, 32'h55,   32'h7, 1'b1, 5'd1, 32'h12345678,
      mk(1, 32'h0C, 32'h55, 32'h12345678, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0)});
    vecs.push_back('{"add_byp_nowe", 1'b1, 32'h001101B3, 32'h0C, 32'h66,   32'h7, 1'b0, 5'd2, 32'hDEADBEEF,
      mk(1, 32'h0C, 32'h66, 32'h7, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0)});
    vecs.push_back('{"beq_p8",       1'b1, 32'h00208463, 32'h10, 32'h1,    32'h2, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h10, 32'h1, 32'h2, 32'h8, 5'd8, 5'd1, 5'd2, 3'd0, 0, C_BR, 2'b01, 0)});
    vecs.push_back('{"beq_m4",       1'b1, 32'hFE000EE3, 32'h14, 32'h3,    32'h3, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h14, 32'h3, 32'h3, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, 3'd0, 1, C_BR, 2'b01, 0)});
    vecs.push_back('{"jal_p8",       1'b1, 32'h008000EF, 32'h18, 32'h0,    32'h9, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h18, 32'h0, 32'h9, 32'h8, 5'd1, 5'd0, 5'd8, 3'd0, 0, C_RW|C_JAL, 2'b00, 0)});
    vecs.push_back('{"jalr",         1'b1, 32'h000080E7, 32'h1C, 32'h400,  32'h0, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h1C, 32'h400, 32'h0, 32'h0, 5'd1, 5'd1, 5'd0, 3'd0, 0, C_RW|C_JALR|C_AS, 2'b00, 0)});
    vecs.push_back('{"lui_rd0",      1'b1, 32'h12345037, 32'h20, 32'hA,    32'hB, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h20, 32'hA, 32'hB, 32'h12345000, 5'd0, 5'd8, 5'd3, 3'd5, 0, C_LUI|C_AS, 2'b00, 0)});
    vecs.push_back('{"auipc",        1'b1, 32'hFFFFF297, 32'h24, 32'hC,    32'hD, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h24, 32'hC, 32'hD, 32'hFFFFF000, 5'd5, 5'd31, 5'd31, 3'd7, 1, C_RW|C_AUI|C_AS, 2'b00, 0)});
    vecs.push_back('{"lw",           1'b1, 32'h0000A103, 32'h28, 32'h1000, 32'h0, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h28, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd1, 5'd0, 3'd2, 0, C_RW|C_MR|C_AS, 2'b00, 0)});
    vecs.push_back('{"sub_rd0",      1'b1, 32'h40208033, 32'h2C, 32'h9,    32'h4, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h2C, 32'h9, 32'h4, 32'h0, 5'd0, 5'd1, 5'd2, 3'd0, 1, 9'd0, 2'b10, 0)});
    vecs.push_back('{"illegal",      1'b1, 32'hFFFFFFFF, 32'h40, 32'h1,    32'h1, 1'b0, 5'd0, 32'h0,
      mk(0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 9'd0, 2'b00, 1)});
    vecs.push_back('{"not_valid",    1'b0, 32'h00500093, 32'h44, 32'h5,    32'h6, 1'b0, 5'd0, 32'h0, '0});
    vecs.push_back('{"addi_m1",      1'b1, 32'hFFF08093, 32'h48, 32'h10,   32'h20, 1'b0, 5'd0, 32'h0,
      mk(1, 32'h48, 32'h10, 32'h20, 32'hFFFFFFFF, 5'd1, 5'd1, 5'd31, 3'd0, 1, C_RW|C_AS, 2'b10, 0)});

    e_addi = mk(1, 32'h200, 32'h0, 32'h0, 32'h5, 5'd1, 5'd0, 5'd5, 3'd0, 0, C_RW|C_AS, 2'b10, 0);

    // Reset
    reset = 1'b0;
    idle();
    tick();
    tick();
    check_out("reset_state", '0);
    check_bit("reset_stall", bus.stall_if, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Table: each vector follows a bubble so no load-use interaction leaks between rows
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      idle();
      @(negedge clk);
      drive(vecs[i].if_valid, vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2,
            vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data, 1'b0, 1'b0);
      #1;
      check_idx({vecs[i].name, "_rs1idx"}, bus.rs1_indice, vecs[i].instr[19:15]);
      exp_q.push_back(vecs[i].exp);
      tick();
      got_sb = exp_q.pop_front();
      check_out(vecs[i].name, got_sb);
    end

    // Load-use on rs1: lw x2 then add x3,x2,x1
    @(negedge clk); idle();
    @(negedge clk); simple(32'h0000A103, 32'h100, 32'h200, 32'h0, 0, 0);
    tick();
    check_bit("lu_lw_memread", bus.id_ex_memread, 1'b1);
    @(negedge clk); simple(32'h001101B3, 32'h104, 32'h5, 32'h6, 0, 0);
    #1;
    check_bit("lu_stall", bus.stall_if, 1'b1);
    tick();
    check_out("lu_bubble", '0);
    check_bit("lu_release", bus.stall_if, 1'b0);
    tick();
    check_out("lu_add_loaded",
      mk(1, 32'h104, 32'h5, 32'h6, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0));

    // Load-use on rs2 only: lw x2 then sw x2,0(x0)
    @(negedge clk); simple(32'h0000A103, 32'h110, 32'h0, 32'h0, 0, 0);
    tick();
    @(negedge clk); simple(32'h00202023, 32'h114, 32'h0, 32'h0, 0, 0);
    #1;
    check_bit("lu_rs2_stall", bus.stall_if, 1'b1);

    // No hazard when the matching field is not a used source (lui with rs1 field = x2)
    @(negedge clk); idle();
    @(negedge clk); simple(32'h0000A103, 32'h120, 32'h0, 32'h0, 0, 0);
    tick();
    @(negedge clk); simple(32'h00010137, 32'h124, 32'h0, 32'h0, 0, 0);
    #1;
    check_bit("lui_no_stall", bus.stall_if, 1'b0);
    tick();
    check_out("lui_loaded",
      mk(1, 32'h124, 32'h0, 32'h0, 32'h00010000, 5'd2, 5'd2, 5'd0, 3'd0, 0, C_RW|C_LUI|C_AS, 2'b00, 0));

    // mem_hold for 3 cycles freezes ID/EX
    @(negedge clk); simple(32'h00500093, 32'h200, 32'h0, 32'h0, 0, 0);
    tick();
    check_out("hold_pre", e_addi);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); simple(32'h001101B3, 32'h204, 32'h1, 32'h2, 0, 1);
      #1;
      check_bit($sformatf("hold_stall_%0d", c), bus.stall_if, 1'b1);
      tick();
      check_out($sformatf("hold_frozen_%0d", c), e_addi);
    end
    @(negedge clk); simple(32'h001101B3, 32'h204, 32'h1, 32'h2, 0, 0);
    tick();
    check_out("hold_release",
      mk(1, 32'h204, 32'h1, 32'h2, 32'h0, 5'd3, 5'd2, 5'd1, 3'd0, 0, C_RW, 2'b10, 0));

    // Flush beats hold and load-use
    @(negedge clk); simple(32'h0000A103, 32'h300, 32'h0, 32'h0, 0, 0);
    tick();
    @(negedge clk); simple(32'h001101B3, 32'h304, 32'h1, 32'h2, 1, 1);
    #1;
    check_bit("flush_no_stall", bus.stall_if, 1'b0);
    tick();
    check_out("flush_bubble", '0);

    // Illegal: pulse, then dropped under hold with pc retained
    @(negedge clk); simple(32'hFFFFFFFF, 32'h40, 32'h0, 32'h0, 0, 0);
    tick();
    check_out("illegal_pulse",
      mk(0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 9'd0, 2'b00, 1));
    @(negedge clk); simple(32'h00500093, 32'h44, 32'h0, 32'h0, 0, 1);
    tick();
    check_out("illegal_hold_drop",
      mk(0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 9'd0, 2'b00, 0));

    // Flushed illegal produces no pulse
    @(negedge clk); simple(32'hFFFFFFFF, 32'h48, 32'h0, 32'h0, 1, 0);
    tick();
    check_out("illegal_flushed", '0);

    // Reset asserted during a hold
    @(negedge clk); simple(32'h00500093, 32'h200, 32'h0, 32'h0, 0, 0);
    tick();
    check_out("rst_pre", e_addi);
    @(negedge clk); simple(32'h001101B3, 32'h204, 32'h1, 32'h2, 0, 1);
    reset = 1'b0;
    tick();
    check_out("rst_mid_stall", '0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
